morse_char_assembler: RTL

Assembles the single-cycle dot/dash/letter-gap/word-gap pulses from the Morse symbol FSM into ASCII characters and buffers them for a downstream consumer such as a display or UART. It sits directly after the symbol FSM. It collects up to MAX_SYM symbols per character, translates them through a lookup, inserts word spaces, and presents characters on a valid/ready interface backed by a small FIFO.

---
 rtl/morse_pkg.sv | 26 ++
 rtl/morse_lut.sv | 70 +++++++
 rtl/morse_char_assembler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse character assembler.
//   - state_e        : assembler FSM encoding
//   - ASCII_QMARK    : character pushed for unknown or over-long codes
//   - ASCII_SPACE    : character pushed on a word gap
//   - MAX_SYM_DEF    : default maximum symbols per character
//   - CNT_W / CHAR_W : symbol-count and character widths
package morse_pkg;

  localparam int unsigned MAX_SYM_DEF = 5;
  localparam int unsigned PAT_W_DEF   = MAX_SYM_DEF;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned CHAR_W      = 8;
  // Longest code the lookup table knows about (digits are five symbols).
  localparam int unsigned LUT_PAT_W   = 5;

  localparam logic [CHAR_W-1:0] ASCII_QMARK = 8'h3F;
  localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COLLECT    = 2'd1,
    EMIT       = 2'd2,
    EMIT_SPACE = 2'd3
  } state_e;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse-to-ASCII lookup for A-Z and 0-9.
// Ports:
//   i_count   : number of symbols in the code (1..5 meaningful)
//   i_pattern : symbols, first symbol at bit i_count-1, dot=0 dash=1
//   o_ascii   : translated character, '?' when the code is unknown
//   o_valid   : 1 when the code maps to a known character
module morse_lut
  import morse_pkg::*;
#(
  parameter int unsigned MAX_SYM = MAX_SYM_DEF
) (
  input  logic [CNT_W-1:0]   i_count,
  input  logic [MAX_SYM-1:0] i_pattern,
  output logic [CHAR_W-1:0]  o_ascii,
  output logic               o_valid
);

  // Bits above i_count are always zero, so an exact match on {count, pattern} works.
  logic [LUT_PAT_W-1:0] w_pat;
  logic [CHAR_W-1:0]    w_code;

  assign w_pat = LUT_PAT_W'(i_pattern);

  always_comb begin
    w_code = 8'h00;
    case ({i_count, w_pat})
      {3'd1, 5'b00000}: w_code = "E";
      {3'd1, 5'b00001}: w_code = "T";
      {3'd2, 5'b00001}: w_code = "A";
      {3'd2, 5'b00000}: w_code = "I";
      {3'd2, 5'b00011}: w_code = "M";
      {3'd2, 5'b00010}: w_code = "N";
      {3'd3, 5'b00100}: w_code = "D";
      {3'd3, 5'b00110}: w_code = "G";
      {3'd3, 5'b00101}: w_code = "K";
      {3'd3, 5'b00111}: w_code = "O";
      {3'd3, 5'b00010}: w_code = "R";
      {3'd3, 5'b00000}: w_code = "S";
      {3'd3, 5'b00001}: w_code = "U";
      {3'd3, 5'b00011}: w_code = "W";
      {3'd4, 5'b01000}: w_code = "B";
      {3'd4, 5'b01010}: w_code = "C";
      {3'd4, 5'b00010}: w_code = "F";
      {3'd4, 5'b00000}: w_code = "H";
      {3'd4, 5'b00111}: w_code = "J";
      {3'd4, 5'b00100}: w_code = "L";
      {3'd4, 5'b00110}: w_code = "P";
      {3'd4, 5'b01101}: w_code = "Q";
      {3'd4, 5'b00001}: w_code = "V";
      {3'd4, 5'b01001}: w_code = "X";
      {3'd4, 5'b01011}: w_code = "Y";
      {3'd4, 5'b01100}: w_code = "Z";
      {3'd5, 5'b11111}: w_code = "0";
      {3'd5, 5'b01111}: w_code = "1";
      {3'd5, 5'b00111}: w_code = "2";
      {3'd5, 5'b00011}: w_code = "3";
      {3'd5, 5'b00001}: w_code = "4";
      {3'd5, 5'b00000}: w_code = "5";
      {3'd5, 5'b10000}: w_code = "6";
      {3'd5, 5'b11000}: w_code = "7";
      {3'd5, 5'b11100}: w_code = "8";
      {3'd5, 5'b11110}: w_code = "9";
      default:          w_code = 8'h00;
    endcase
  end

  assign o_valid = (w_code != 8'h00);
  assign o_ascii = o_valid ? w_code : ASCII_QMARK;

endmodule

// File: rtl/morse_char_assembler.sv
// Assembles dot/dash/letter-gap/word-gap pulses into ASCII characters and
// buffers them in a small FIFO with a valid/ready output.
// Ports:
//   clk, reset_n           : clock, async active-low reset
//   dot_in/dash_in         : symbol pulses (dash wins if both)
//   lg_in/wg_in            : letter-gap / word-gap pulses (wg wins)
//   char_out/char_valid    : FIFO head and not-empty flag
//   char_ready             : consumer accept; transfer on valid & ready
//   sym_count              : symbols collected for the current character
//   overflow/too_long      : sticky error flags, cleared only by reset
module morse_char_assembler
  import morse_pkg::*;
#(
  parameter int unsigned MAX_SYM    = MAX_SYM_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dot_in,
  input  logic              dash_in,
  input  logic              lg_in,
  input  logic              wg_in,
  output logic [CHAR_W-1:0] char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [CNT_W-1:0]  sym_count,
  output logic              overflow,
  output logic              too_long
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  state_e               r_state,      w_state_nxt;
  logic [MAX_SYM-1:0]   r_pattern,    w_pattern_nxt;
  logic [CNT_W-1:0]     r_count,      w_count_nxt;
  logic                 r_invalid,    w_invalid_nxt;
  logic                 r_pending,    w_pending_nxt;
  logic                 r_last_space, w_last_space_nxt;
  logic                 r_too_long,   w_too_long_nxt;
  logic                 r_overflow;

  logic                 w_push;
  logic [CHAR_W-1:0]    w_push_data;
  logic [CHAR_W-1:0]    w_lut_ascii;
  logic                 w_lut_valid;
  logic                 w_sym_any;
  logic                 w_sym_bit;

  logic [CHAR_W-1:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push_ok;
  logic                 w_drop;

  // Dash outranks dot when both arrive together.
  assign w_sym_any = dot_in | dash_in;
  assign w_sym_bit = dash_in;

  morse_lut #(
    .MAX_SYM (MAX_SYM)
  ) u_lut (
    .i_count   (r_count),
    .i_pattern (r_pattern),
    .o_ascii   (w_lut_ascii),
    .o_valid   (w_lut_valid)
  );

  // FSM state and collection registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_pattern    <= '0;
      r_count      <= '0;
      r_invalid    <= 1'b0;
      r_pending    <= 1'b0;
      r_last_space <= 1'b0;
      r_too_long   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pattern    <= w_pattern_nxt;
      r_count      <= w_count_nxt;
      r_invalid    <= w_invalid_nxt;
      r_pending    <= w_pending_nxt;
      r_last_space <= w_last_space_nxt;
      r_too_long   <= w_too_long_nxt;
    end
  end

  // Next-state, collection and FIFO-push decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_pattern_nxt    = r_pattern;
    w_count_nxt      = r_count;
    w_invalid_nxt    = r_invalid;
    w_pending_nxt    = r_pending;
    w_last_space_nxt = r_last_space;
    w_too_long_nxt   = r_too_long;
    w_push           = 1'b0;
    w_push_data      = 8'h00;

    case (r_state)
      IDLE: begin
        if (wg_in) begin
          // Suppress back-to-back spaces from repeated word gaps.
          if (!r_last_space) w_state_nxt = EMIT_SPACE;
        end else if (!lg_in && w_sym_any) begin
          w_pattern_nxt = MAX_SYM'(w_sym_bit);
          w_count_nxt   = CNT_W'(1);
          w_state_nxt   = COLLECT;
        end
      end

      COLLECT: begin
        if (wg_in) begin
          w_pending_nxt = 1'b1;
          w_state_nxt   = EMIT;
        end else if (lg_in) begin
          w_state_nxt   = EMIT;
        end else if (w_sym_any) begin
          if (r_count < CNT_W'(MAX_SYM)) begin
            w_pattern_nxt = (r_pattern << 1) | MAX_SYM'(w_sym_bit);
            w_count_nxt   = r_count + CNT_W'(1);
          end else begin
            w_too_long_nxt = 1'b1;
            w_invalid_nxt  = 1'b1;
          end
        end
      end

      EMIT: begin
        w_push           = 1'b1;
        w_push_data      = (r_invalid || !w_lut_valid) ? ASCII_QMARK : w_lut_ascii;
        w_pattern_nxt    = '0;
        w_count_nxt      = '0;
        w_invalid_nxt    = 1'b0;
        w_last_space_nxt = 1'b0;
        w_state_nxt      = r_pending ? EMIT_SPACE : IDLE;
      end

      EMIT_SPACE: begin
        w_push           = 1'b1;
        w_push_data      = ASCII_SPACE;
        w_last_space_nxt = 1'b1;
        w_pending_nxt    = 1'b0;
        w_state_nxt      = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // Extra pointer bit distinguishes full from empty.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = !w_empty && char_ready;
  // A same-cycle pop frees the slot a push into a full FIFO needs.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  // Output FIFO storage, pointers and overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign char_out   = r_mem[r_rd_ptr[AW-1:0]];
  assign char_valid = !w_empty;
  assign sym_count  = r_count;
  assign overflow   = r_overflow;
  assign too_long   = r_too_long;

endmodule
